// File: rtl/ip_csum_stream_if.sv
// rtl/ip_csum_stream_if.sv - packet tap and checksum result bundle for ip_csum_stream
interface ip_csum_stream_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic [15:0]      o_csum;
  logic             o_ok;
  logic             o_short;
  logic             o_valid;
  logic             o_ready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_ready,
    output i_tready, o_csum, o_ok, o_short, o_valid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_ready,
    input  i_tready, o_csum, o_ok, o_short, o_valid
  );
endinterface

// File: rtl/ip_csum_stream.sv
// rtl/ip_csum_stream.sv - streaming 16-bit ones-complement checksum over a word window per packet
module ip_csum_stream #(
  parameter int WIDTH     = 64,
  parameter int HDR_START = 7,
  parameter int HDR_WORDS = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  ip_csum_stream_if.slave bus
);
  localparam int          LANES   = WIDTH / 16;
  localparam logic [31:0] WIN_LO  = 32'(HDR_START);
  localparam logic [31:0] WIN_HI  = 32'(HDR_START + HDR_WORDS);
  localparam logic [31:0] LANES_W = 32'(LANES);

  typedef enum logic [1:0] {SUM, FOLD1, FOLD2, HOLD} state_t;

  state_t      state, state_next;
  logic        accept;
  logic [31:0] acc, wcnt, beat_sum, total, wcnt_inc, wcnt_next, sum_r;
  logic [16:0] s1;
  logic [15:0] s2;
  logic        pend_short;
  logic [15:0] csum_r;
  logic        ok_r, short_r;

  // Lanes whose running word index falls outside the window contribute 0.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if ((wcnt + 32'(k)) >= WIN_LO && (wcnt + 32'(k)) < WIN_HI)
        beat_sum = beat_sum + {16'h0000, bus.i_tdata[WIDTH-1-16*k -: 16]};
    end
  end

  assign total     = acc + beat_sum;
  assign wcnt_inc  = wcnt + LANES_W;
  assign wcnt_next = (wcnt_inc > WIN_HI) ? WIN_HI : wcnt_inc;
  assign s2        = s1[15:0] + {15'h0000, s1[16]};

  always_comb begin
    state_next = state;
    accept     = bus.i_tvalid && (state == SUM);
    case (state)
      SUM:     if (accept && bus.i_tlast) state_next = FOLD1;
      FOLD1:   state_next = FOLD2;
      FOLD2:   state_next = HOLD;
      HOLD:    if (bus.o_ready) state_next = SUM;
      default: state_next = SUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SUM;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      wcnt       <= '0;
      sum_r      <= '0;
      pend_short <= 1'b0;
      s1         <= '0;
      csum_r     <= '0;
      ok_r       <= 1'b0;
      short_r    <= 1'b0;
    end else begin
      case (state)
        SUM: begin
          if (accept) begin
            if (bus.i_tlast) begin
              sum_r      <= total;
              pend_short <= (wcnt_next < WIN_HI);
              acc        <= '0;
              wcnt       <= '0;
            end else begin
              acc  <= total;
              wcnt <= wcnt_next;
            end
          end
        end
        FOLD1: s1 <= {1'b0, sum_r[15:0]} + {1'b0, sum_r[31:16]};
        FOLD2: begin
          csum_r  <= ~s2;
          ok_r    <= (s2 == 16'hFFFF);
          short_r <= pend_short;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode only the state register, never o_ready.
  assign bus.i_tready = (state == SUM);
  assign bus.o_valid  = (state == HOLD);
  assign bus.o_csum   = csum_r;
  assign bus.o_ok     = ok_r;
  assign bus.o_short  = short_r;
endmodule
